// File: rtl/mlp_arb_pkg.sv
// Shared types and constants for the MLP accelerator's 5-way request arbiter.
package mlp_arb_pkg;

   localparam int NumReq = 5;

   typedef logic [2:0] grant_t;

   localparam grant_t GrantNone = 3'b111;

   typedef enum logic {ST_IDLE, ST_BUSY} arb_state_e;

   // Round-robin successor of a granted index, wrapping 4 -> 0.
   function automatic grant_t next_ptr(input grant_t g);
      return (g == grant_t'(NumReq - 1)) ? '0 : g + 3'd1;
   endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational rotating-priority picker: first eligible index scanning ptr, ptr+1, ... mod 5.
module rr_pick5
   import mlp_arb_pkg::*;
(
   input  logic [NumReq-1:0] elig,
   input  grant_t            ptr,
   output logic              found,
   output grant_t            idx
);

   // Scan from the farthest offset down so the offset closest to ptr is written last and wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = NumReq - 1; k >= 0; k--) begin
         if (elig[(int'(ptr) + k) % NumReq]) begin
            found = 1'b1;
            idx   = grant_t'((int'(ptr) + k) % NumReq);
         end
      end
   end

endmodule

// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel among 5 requesters, with burst lock and overflow flag.
module mux5_rr_arbiter
   import mlp_arb_pkg::*;
#(
   parameter  int DWidth   = 32,
   parameter  int MaxBeats = 256,
   localparam int CntWidth = $clog2(MaxBeats + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NumReq-1:0]          req_valid_i,
   input  logic [NumReq-1:0]          req_last_i,
   input  logic [NumReq*DWidth-1:0]   req_data_i,
   input  logic [NumReq-1:0]          req_mask_i,
   output logic [NumReq-1:0]          req_ready_o,
   output logic                       out_valid_o,
   output logic                       out_last_o,
   output logic [DWidth-1:0]          out_data_o,
   input  logic                       out_ready_i,
   output grant_t                     grant_o,
   output logic                       busy_o,
   output logic                       err_o,
   input  logic                       err_clr_i
);

   arb_state_e          state, state_d;
   grant_t              grant, grant_d;
   grant_t              ptr, ptr_d;
   logic [CntWidth-1:0] cnt, cnt_d;
   logic                err, err_d;
   logic                pick_found;
   grant_t              pick_idx;
   logic                xfer;

   rr_pick5 u_pick (
      .elig  (req_valid_i & req_mask_i),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // 5:1 data/handshake mux; GrantNone selects nothing, so idle outputs fall to zero.
   always_comb begin
      out_valid_o = 1'b0;
      out_last_o  = 1'b0;
      out_data_o  = '0;
      req_ready_o = '0;
      for (int i = 0; i < NumReq; i++) begin
         if (grant == grant_t'(i)) begin
            out_valid_o    = req_valid_i[i];
            out_last_o     = req_last_i[i];
            out_data_o     = req_data_i[i*DWidth +: DWidth];
            req_ready_o[i] = out_ready_i;
         end
      end
   end

   assign xfer = out_valid_o & out_ready_i;

   always_comb begin
      state_d = state;
      grant_d = grant;
      ptr_d   = ptr;
      cnt_d   = cnt;
      err_d   = err & ~err_clr_i;
      unique case (state)
         ST_IDLE: begin
            if (pick_found) begin
               state_d = ST_BUSY;
               grant_d = pick_idx;
               cnt_d   = '0;
            end
         end
         ST_BUSY: begin
            if (xfer && out_last_o) begin
               state_d = ST_IDLE;
               grant_d = GrantNone;
               ptr_d   = next_ptr(grant);
            end else if (xfer) begin
               // Overflow is flagged but the grant is kept until the requester's own last beat.
               if (cnt == CntWidth'(MaxBeats - 1)) begin
                  err_d = 1'b1;
               end
               if (cnt != CntWidth'(MaxBeats)) begin
                  cnt_d = cnt + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         grant <= GrantNone;
         ptr   <= '0;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_d;
         grant <= grant_d;
         ptr   <= ptr_d;
         cnt   <= cnt_d;
         err   <= err_d;
      end
   end

   assign grant_o = grant;
   assign busy_o  = (state == ST_BUSY);
   assign err_o   = err;

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Self-checking bench for mux5_rr_arbiter: directed scenarios plus random traffic against a burst-level model.
module tb_mux5_rr_arbiter;

   localparam int DW   = 32;
   localparam int MAXB = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [4:0]      req_valid_i;
   logic [4:0]      req_last_i;
   logic [5*DW-1:0] req_data_i;
   logic [4:0]      req_mask_i;
   logic [4:0]      req_ready_o;
   logic            out_valid_o;
   logic            out_last_o;
   logic [DW-1:0]   out_data_o;
   logic            out_ready_i;
   logic [2:0]      grant_o;
   logic            busy_o;
   logic            err_o;
   logic            err_clr_i;

   logic [DW-1:0]   dv [5];

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: who owns the channel, whose turn is next, beats moved so far, error flag.
   bit m_busy;
   int m_owner;
   int m_ptr;
   int m_beats;
   bit m_err;
   bit m_xfer;

   always #5 clk = ~clk;

   mux5_rr_arbiter #(.DWidth(DW), .MaxBeats(MAXB)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid_i),
      .req_last_i  (req_last_i),
      .req_data_i  (req_data_i),
      .req_mask_i  (req_mask_i),
      .req_ready_o (req_ready_o),
      .out_valid_o (out_valid_o),
      .out_last_o  (out_last_o),
      .out_data_o  (out_data_o),
      .out_ready_i (out_ready_i),
      .grant_o     (grant_o),
      .busy_o      (busy_o),
      .err_o       (err_o),
      .err_clr_i   (err_clr_i)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic modelReset();
      m_busy  = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_beats = 0;
      m_err   = 1'b0;
      m_xfer  = 1'b0;
   endtask

   task automatic checkAll();
      logic [2:0]    e_grant;
      logic          e_valid, e_last;
      logic [DW-1:0] e_data;
      logic [4:0]    e_ready;
      e_grant = m_busy ? 3'(m_owner) : 3'b111;
      e_valid = m_busy && req_valid_i[m_owner];
      e_last  = m_busy && req_last_i[m_owner];
      e_data  = m_busy ? dv[m_owner] : '0;
      e_ready = (m_busy && out_ready_i) ? (5'b00001 << m_owner) : 5'b00000;
      checkOutput("grant", 32'(grant_o), 32'(e_grant));
      checkOutput("busy", 32'(busy_o), 32'(m_busy));
      checkOutput("out_valid", 32'(out_valid_o), 32'(e_valid));
      checkOutput("out_last", 32'(out_last_o), 32'(e_last));
      checkOutput("out_data", out_data_o, e_data);
      checkOutput("req_ready", 32'(req_ready_o), 32'(e_ready));
      checkOutput("err", 32'(err_o), 32'(m_err));
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic modelStep();
      bit set_err;
      set_err = 1'b0;
      m_xfer  = 1'b0;
      if (!m_busy) begin
         for (int k = 0; k < 5; k++) begin
            int c;
            c = (m_ptr + k) % 5;
            if (!m_busy && req_valid_i[c] && req_mask_i[c]) begin
               m_busy  = 1'b1;
               m_owner = c;
               m_beats = 0;
            end
         end
      end else if (req_valid_i[m_owner] && out_ready_i) begin
         m_xfer = 1'b1;
         if (req_last_i[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % 5;
         end else begin
            if (m_beats == MAXB - 1) set_err = 1'b1;
            if (m_beats < MAXB) m_beats++;
         end
      end
      if (set_err) m_err = 1'b1;
      else if (err_clr_i) m_err = 1'b0;
   endtask

   task automatic applyStimulus(input logic [4:0] v, input logic [4:0] l, input logic [4:0] m,
                                input logic r, input logic c);
      @(negedge clk);
      req_valid_i = v;
      req_last_i  = l;
      req_mask_i  = m;
      out_ready_i = r;
      err_clr_i   = c;
      for (int i = 0; i < 5; i++) begin
         dv[i] = $urandom;
         req_data_i[i*DW +: DW] = dv[i];
      end
      #1;
      checkAll();
      modelStep();
   endtask

   task automatic clearInputs();
      req_valid_i = '0;
      req_last_i  = '0;
      req_mask_i  = '0;
      out_ready_i = 1'b0;
      err_clr_i   = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      clearInputs();
      #1;
      modelReset();
      checkAll();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int sent;
      rst = 1'b1;
      clearInputs();
      req_data_i = '0;
      for (int i = 0; i < 5; i++) dv[i] = '0;
      #1;
      modelReset();
      checkAll();
      @(negedge clk);
      rst = 1'b0;

      // Single 1-beat burst from requester 2, then everyone requests: pointer should have moved to 3.
      applyStimulus(5'b00100, 5'b00100, 5'b11111, 1'b1, 1'b0);
      applyStimulus(5'b00100, 5'b00100, 5'b11111, 1'b1, 1'b0);
      applyStimulus(5'b00000, 5'b00000, 5'b11111, 1'b1, 1'b0);
      applyStimulus(5'b11111, 5'b11111, 5'b11111, 1'b1, 1'b0);
      applyStimulus(5'b11111, 5'b11111, 5'b11111, 1'b1, 1'b0);
      checkOutput("ptr_after_2", 32'(grant_o), 32'd3);

      // Continuous 1-beat bursts from all requesters starting at reset.
      doReset();
      for (int i = 0; i < 12; i++) applyStimulus(5'b11111, 5'b11111, 5'b11111, 1'b1, 1'b0);

      // 4-beat burst on requester 1 with toggling ready while requester 3 waits.
      doReset();
      sent = 0;
      for (int i = 0; i < 20 && sent < 4; i++) begin
         applyStimulus(5'b01010, 5'b01000 | ((sent == 3) ? 5'b00010 : 5'b00000), 5'b11111,
                       1'(i % 2 == 0), 1'b0);
         if (m_xfer) sent++;
      end
      checkOutput("burst4_beats", 32'(sent), 32'd4);
      for (int i = 0; i < 3; i++) applyStimulus(5'b01000, 5'b01000, 5'b11111, 1'b1, 1'b0);

      // Mask excludes requester 0; dropping requester 4's mask mid-burst keeps the grant.
      doReset();
      applyStimulus(5'b10001, 5'b00000, 5'b11110, 1'b1, 1'b0);
      applyStimulus(5'b10001, 5'b00000, 5'b01110, 1'b1, 1'b0);
      applyStimulus(5'b10001, 5'b00000, 5'b01110, 1'b1, 1'b0);
      checkOutput("mask_hold", 32'(grant_o), 32'd4);
      applyStimulus(5'b10001, 5'b10000, 5'b01110, 1'b1, 1'b0);
      applyStimulus(5'b00000, 5'b00000, 5'b11111, 1'b1, 1'b0);

      // 6-beat burst overflows MaxBeats=4, then clear; second overflow with clear held (set wins).
      doReset();
      applyStimulus(5'b00001, 5'b00000, 5'b11111, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(5'b00001, 5'b00000, 5'b11111, 1'b1, 1'b0);
      applyStimulus(5'b00001, 5'b00001, 5'b11111, 1'b1, 1'b0);
      applyStimulus(5'b00000, 5'b00000, 5'b11111, 1'b1, 1'b1);
      applyStimulus(5'b00000, 5'b00000, 5'b11111, 1'b1, 1'b0);
      checkOutput("err_cleared", 32'(err_o), 32'd0);
      applyStimulus(5'b00001, 5'b00000, 5'b11111, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(5'b00001, 5'b00000, 5'b11111, 1'b1, 1'b1);
      applyStimulus(5'b00001, 5'b00001, 5'b11111, 1'b1, 1'b0);
      applyStimulus(5'b00000, 5'b00000, 5'b11111, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a 3-beat burst on requester 2.
      doReset();
      applyStimulus(5'b00100, 5'b00000, 5'b11111, 1'b1, 1'b0);
      applyStimulus(5'b00100, 5'b00000, 5'b11111, 1'b1, 1'b0);
      applyStimulus(5'b00100, 5'b00000, 5'b11111, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      modelReset();
      checkAll();
      @(negedge clk);
      clearInputs();
      rst = 1'b0;
      applyStimulus(5'b11111, 5'b11111, 5'b11111, 1'b1, 1'b0);
      applyStimulus(5'b11111, 5'b11111, 5'b11111, 1'b1, 1'b0);
      checkOutput("ptr_after_rst", 32'(grant_o), 32'd0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic [4:0] v, l, m;
         v = 5'($urandom) | 5'($urandom);
         l = 5'($urandom) & 5'($urandom);
         m = 5'($urandom) | 5'($urandom);
         applyStimulus(v, l, m, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
